// File: rtl/spmv_mac_pkg.sv
// Shared constants and result-entry type for the sparse row multiply-accumulate block.
package spmv_mac_pkg;

    localparam int S1_LAT      = 1;
    localparam int S2_LAT      = 2;
    localparam int S3_LAT      = 3;
    localparam int STALL_SLACK = 4;

    // Entry fields are sized for the widest legal configuration; users slice down.
    localparam int RES_ROW_MAX = 32;
    localparam int RES_ACC_MAX = 256;

    typedef struct packed {
        logic [RES_ROW_MAX-1:0] row;
        logic [RES_ACC_MAX-1:0] sum;
    } res_entry_t;

endpackage

// File: rtl/spmv_result_fifo.sv
// Show-ahead result buffer with occupancy count; write and pop may coincide even when full.
module spmv_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         full, do_wr, do_rd;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spmv_row_mac.sv
// Streaming row-sum MAC: products of equal-row runs are accumulated and emitted per run.
// Optional macro SPMV_ROW_MAC_SATURATE_EN selects saturating instead of wrapping accumulation.
module spmv_row_mac
    import spmv_mac_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 80,
    parameter int ROW_W      = 10,
    parameter int FIFO_DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [ROW_W-1:0]         row,
    input  logic signed [DATA_W-1:0] v0,
    input  logic signed [DATA_W-1:0] v1,
    input  logic                     eof,
    output logic                     stall,
    input  logic                     stall_out,
    output logic                     push_out,
    output logic [ROW_W-1:0]         row_out,
    output logic signed [ACC_W-1:0]  v_out,
    output logic                     done
);
    localparam int EW = ROW_W + ACC_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [S2_LAT:S1_LAT]     vld_pipe, eof_pipe;
    logic [ROW_W-1:0]         s1_row, s2_row, run_row;
    logic signed [DATA_W-1:0] s1_v0, s1_v1;
    logic signed [ACC_W-1:0]  s2_prod, run_sum, acc_nxt;
    logic                     run_open, eof_lat, eof_busy, stall_q;
    logic                     pipe_empty, new_run, flush, fifo_wr, done_i;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_cnt;
    logic [EW-1:0]            fifo_wdata, fifo_rdata;
    res_entry_t               wr_ent;
    logic                     unused_ent;

    // eof travels with the data so it reaches S3 behind every product issued with or before it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            eof_pipe <= '0;
            s1_row   <= '0;
            s1_v0    <= '0;
            s1_v1    <= '0;
            s2_row   <= '0;
            s2_prod  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[S2_LAT-1:S1_LAT], wr};
            eof_pipe <= {eof_pipe[S2_LAT-1:S1_LAT], eof};
            if (wr) begin
                s1_row <= row;
                s1_v0  <= v0;
                s1_v1  <= v1;
            end
            if (vld_pipe[S1_LAT]) begin
                s2_row  <= s1_row;
                s2_prod <= ACC_W'(s1_v0 * s1_v1);
            end
        end
    end

`ifdef SPMV_ROW_MAC_SATURATE_EN
    logic [ACC_W:0] acc_wide;
    always_comb begin
        acc_wide = {run_sum[ACC_W-1], run_sum} + {s2_prod[ACC_W-1], s2_prod};
        acc_nxt  = acc_wide[ACC_W-1:0];
        if (acc_wide[ACC_W] != acc_wide[ACC_W-1])
            acc_nxt = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_nxt = run_sum + s2_prod;
`endif

    assign pipe_empty = ~|vld_pipe;
    assign new_run    = vld_pipe[S2_LAT] && run_open && (s2_row != run_row);
    assign flush      = eof_lat && pipe_empty && run_open;
    assign fifo_wr    = new_run || flush;
    assign done_i     = eof_lat && pipe_empty && !run_open && fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_open <= 1'b0;
            run_row  <= '0;
            run_sum  <= '0;
            eof_lat  <= 1'b0;
            eof_busy <= 1'b0;
            stall_q  <= 1'b1;
        end else begin
            if (vld_pipe[S2_LAT]) begin
                run_open <= 1'b1;
                if (run_open && (s2_row == run_row)) begin
                    run_sum <= acc_nxt;
                end else begin
                    run_row <= s2_row;
                    run_sum <= s2_prod;
                end
            end else if (flush) begin
                run_open <= 1'b0;
            end
            if (done_i)                eof_lat <= 1'b0;
            else if (eof_pipe[S2_LAT]) eof_lat <= 1'b1;
            eof_busy <= (eof_busy && !done_i) || eof;
            stall_q  <= (fifo_cnt >= CW'(FIFO_DEPTH - STALL_SLACK)) || (eof_busy && !done_i) || eof;
        end
    end

    always_comb begin
        wr_ent     = '0;
        wr_ent.row = RES_ROW_MAX'(run_row);
        wr_ent.sum = RES_ACC_MAX'(run_sum);
        fifo_wdata = {wr_ent.row[ROW_W-1:0], wr_ent.sum[ACC_W-1:0]};
    end
    assign unused_ent = ^wr_ent;

    spmv_result_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (push_out),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign push_out = !fifo_empty && !stall_out;
    assign row_out  = fifo_empty ? '0 : fifo_rdata[EW-1:ACC_W];
    assign v_out    = fifo_empty ? '0 : fifo_rdata[ACC_W-1:0];
    assign done     = done_i;
    assign stall    = stall_q;

endmodule

// File: tb/tb_spmv_row_mac.sv
// Self-checking bench for spmv_row_mac: directed table, corner sequences, random streams vs run model.
module tb_spmv_row_mac;
    localparam int DW = 32;
    localparam int AW = 64;
    localparam int RW = 10;
    localparam int FD = 16;
    localparam logic signed [127:0] MAXV = 128'sh7FFFFFFFFFFFFFFF;
    localparam logic signed [127:0] MINV = -MAXV - 1;
`ifdef SPMV_ROW_MAC_SATURATE_EN
    localparam logic signed [AW-1:0] MAXMAX4 = 64'sh7FFFFFFFFFFFFFFF;
`else
    localparam logic signed [AW-1:0] MAXMAX4 = -64'sd17179869180;
`endif

    logic                 clk = 1'b0, rst = 1'b0, wr = 1'b0, eof = 1'b0, stall_out = 1'b0;
    logic [RW-1:0]        row = '0;
    logic signed [DW-1:0] v0 = '0, v1 = '0;
    logic                 stall, push_out, done;
    logic [RW-1:0]        row_out;
    logic signed [AW-1:0] v_out;

    always #5 clk = ~clk;

    spmv_row_mac #(.DATA_W(DW), .ACC_W(AW), .ROW_W(RW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .wr(wr), .row(row), .v0(v0), .v1(v1), .eof(eof),
        .stall(stall), .stall_out(stall_out), .push_out(push_out),
        .row_out(row_out), .v_out(v_out), .done(done)
    );

    typedef struct {
        logic [RW-1:0]        r;
        logic signed [AW-1:0] s;
    } res_t;

    typedef struct {
        int                   n;
        bit                   eof_same;
        logic [RW-1:0]        r[4];
        logic signed [DW-1:0] a[4];
        logic signed [DW-1:0] b[4];
        int                   ne;
        logic [RW-1:0]        er[4];
        logic signed [AW-1:0] es[4];
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0;
    bit rnd_so = 0;
    res_t got_q[$], exp_q[$];
    logic [RW-1:0]        s_row[$];
    logic signed [DW-1:0] s_a[$], s_b[$];
    vec_t tbl[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (push_out) got_q.push_back('{row_out, v_out});
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_so) stall_out = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wait_not_stall();
        int g = 0;
        while (stall && g < 300) begin
            tick();
            g++;
        end
        if (g >= 300) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout got stall=1 want stall=0");
        end
    endtask

    task automatic send(input logic [RW-1:0] r, input logic signed [DW-1:0] a,
                        input logic signed [DW-1:0] b, input bit e);
        wait_not_stall();
        wr = 1'b1; row = r; v0 = a; v1 = b; eof = e;
        s_row.push_back(r); s_a.push_back(a); s_b.push_back(b);
        tick();
        wr = 1'b0; eof = 1'b0;
    endtask

    task automatic send_eof();
        wait_not_stall();
        eof = 1'b1;
        tick();
        eof = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int start = done_cnt;
        int g = 0;
        while (done_cnt == start && g < 600) begin
            tick();
            g++;
        end
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL %s done_timeout got none want pulse", nm);
        end
        rnd_so = 0;
        stall_out = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic signed [127:0] acc_add(input logic signed [127:0] a,
                                                    input logic signed [127:0] p);
        logic signed [127:0] t;
        t = a + p;
`ifdef SPMV_ROW_MAC_SATURATE_EN
        if (t > MAXV) t = MAXV;
        else if (t < MINV) t = MINV;
`else
        t = $signed(t[63:0]);
`endif
        return t;
    endfunction

    // Group consecutive equal rows into runs and sum each run's products.
    task automatic build_exp();
        logic signed [127:0] acc, p;
        logic [RW-1:0] cr;
        bit open;
        acc = '0; cr = '0; open = 0;
        exp_q.delete();
        foreach (s_row[i]) begin
            p = s_a[i];
            p = p * s_b[i];
            if (open && s_row[i] == cr) begin
                acc = acc_add(acc, p);
            end else begin
                if (open) exp_q.push_back('{cr, acc[63:0]});
                cr = s_row[i];
                acc = p;
                open = 1;
            end
        end
        if (open) exp_q.push_back('{cr, acc[63:0]});
    endtask

    task automatic compare(input string nm);
        int n;
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_row"}, got_q[i].r, exp_q[i].r);
            chk({nm, "_sum"}, got_q[i].s, exp_q[i].s);
        end
        got_q.delete();
    endtask

    task automatic clear_stream();
        s_row.delete(); s_a.delete(); s_b.delete();
        got_q.delete();
    endtask

    initial begin
        int c0;
        tbl[0].n = 3; tbl[0].eof_same = 0; tbl[0].r = '{3, 3, 3, 0};
        tbl[0].a = '{2, 5, -1, 0}; tbl[0].b = '{1, 1, 1, 0};
        tbl[0].ne = 1; tbl[0].er = '{3, 0, 0, 0}; tbl[0].es = '{6, 0, 0, 0};
        tbl[1].n = 3; tbl[1].eof_same = 0; tbl[1].r = '{1, 2, 1, 0};
        tbl[1].a = '{4, 4, 4, 0}; tbl[1].b = '{1, 1, 1, 0};
        tbl[1].ne = 3; tbl[1].er = '{1, 2, 1, 0}; tbl[1].es = '{4, 4, 4, 0};
        tbl[2].n = 1; tbl[2].eof_same = 1; tbl[2].r = '{7, 0, 0, 0};
        tbl[2].a = '{3, 0, 0, 0}; tbl[2].b = '{3, 0, 0, 0};
        tbl[2].ne = 1; tbl[2].er = '{7, 0, 0, 0}; tbl[2].es = '{9, 0, 0, 0};
        tbl[3].n = 4; tbl[3].eof_same = 0; tbl[3].r = '{0, 0, 0, 0};
        tbl[3].a = '{32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        tbl[3].b = '{32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        tbl[3].ne = 1; tbl[3].er = '{0, 0, 0, 0}; tbl[3].es = '{MAXMAX4, 0, 0, 0};

        // reset state
        tick(); tick();
        chk("rst_stall", stall, 1);
        chk("rst_push", push_out, 0);
        chk("rst_done", done, 0);
        chk("rst_row_out", row_out, 0);
        chk("rst_v_out", v_out, 0);
        rst = 1'b1;
        tick();
        chk("stall_after_rst", stall, 0);

        // lone eof on an idle block: done three cycles later, nothing pushed
        clear_stream();
        c0 = cyc;
        eof = 1'b1;
        tick();
        eof = 1'b0;
        wait_done("lone_eof");
        chk("lone_eof_latency", done_cyc - c0, 3);
        chk("lone_eof_pushes", got_q.size(), 0);

        // directed table
        for (int t = 0; t < 4; t++) begin
            clear_stream();
            for (int i = 0; i < tbl[t].n; i++)
                send(tbl[t].r[i], tbl[t].a[i], tbl[t].b[i], tbl[t].eof_same && (i == tbl[t].n - 1));
            if (!tbl[t].eof_same) send_eof();
            wait_done($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_count", t), got_q.size(), tbl[t].ne);
            for (int j = 0; j < tbl[t].ne && j < got_q.size(); j++) begin
                chk($sformatf("tbl%0d_row%0d", t, j), got_q[j].r, tbl[t].er[j]);
                chk($sformatf("tbl%0d_sum%0d", t, j), got_q[j].s, tbl[t].es[j]);
            end
        end

        // backpressure: 13 distinct rows against a blocked consumer
        clear_stream();
        stall_out = 1'b1;
        for (int i = 0; i < 13; i++) send(RW'(10 + i), 32'(i + 1), 3, 0);
        repeat (8) tick();
        chk("bp_stall_high", stall, 1);
        chk("bp_no_push", push_out, 0);
        chk("bp_nothing_out", got_q.size(), 0);
        stall_out = 1'b0;
        send_eof();
        wait_done("bp");
        build_exp();
        chk("bp_model_count", exp_q.size(), 13);
        compare("bp");

        // reset mid-stream with three buffered results
        clear_stream();
        stall_out = 1'b1;
        for (int i = 1; i <= 4; i++) send(RW'(i), 5, 5, 0);
        repeat (6) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 1);
        chk("mid_rst_push", push_out, 0);
        chk("mid_rst_row_out", row_out, 0);
        chk("mid_rst_v_out", v_out, 0);
        tick();
        chk("mid_rst_stall_hold", stall, 1);
        rst = 1'b1;
        stall_out = 1'b0;
        tick();
        chk("mid_rst_release_stall", stall, 0);
        repeat (8) tick();
        chk("mid_rst_no_push", got_q.size(), 0);
        clear_stream();
        send(5, -7, 3, 0);
        send(5, 11, 2, 0);
        send(6, 100, -4, 0);
        send_eof();
        wait_done("post_rst");
        build_exp();
        compare("post_rst");

        // random streams with random downstream backpressure
        for (int s = 0; s < 6; s++) begin
            int n;
            bit es;
            clear_stream();
            rnd_so = 1;
            n = $urandom_range(5, 30);
            es = $urandom_range(0, 1);
            for (int i = 0; i < n; i++) begin
                send(RW'($urandom_range(0, 3)), $urandom, $urandom, es && (i == n - 1));
                if ($urandom_range(0, 2) == 0) tick();
            end
            rnd_so = 1;
            if (!es) send_eof();
            wait_done($sformatf("rnd%0d", s));
            build_exp();
            compare($sformatf("rnd%0d", s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
